// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Sequencer in front of a combinational ALU. It holds the multiply
//            settle window and owns the architectural HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_sign,
    output logic [3:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_carry_in,
    output logic        alu_sign,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_ovf_trap,
    output logic        rsp_illegal,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MULW = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t         state_q;
    logic [4:0]     op_q;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic           sign_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    rsp_data_q;
    logic           rsp_zero_q;
    logic           rsp_ovf_q;
    logic           rsp_ill_q;

    logic [31:0]    data_d;
    logic           ovf_d;
    logic           ill_d;

    // Result selection for every single-cycle (non-multiply) command.
    always_comb begin
        data_d = alu_lo;
        ovf_d  = 1'b0;
        ill_d  = 1'b0;
        case (op_q)
            5'h10:          data_d = hi_q;
            5'h11:          data_d = lo_q;
            5'h12, 5'h13:   data_d = a_q;
            default: begin
                if (op_q[4]) begin
                    data_d = 32'h0;
                    ill_d  = 1'b1;
                end else begin
                    ovf_d = alu_overflow & sign_q & (op_q[3:1] == 3'd0);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= 5'h0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            hi_q       <= 32'h0;
            lo_q       <= 32'h0;
            rsp_data_q <= 32'h0;
            rsp_zero_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_ill_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        sign_q  <= req_sign;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_q == 5'h02) begin
                        cnt_q   <= CW'(MUL_LAT - 1);
                        state_q <= S_MULW;
                    end else begin
                        rsp_data_q <= data_d;
                        rsp_zero_q <= (data_d == 32'h0);
                        rsp_ovf_q  <= ovf_d;
                        rsp_ill_q  <= ill_d;
                        if (op_q == 5'h12) hi_q <= a_q;
                        if (op_q == 5'h13) lo_q <= a_q;
                        state_q <= S_RESP;
                    end
                end
                S_MULW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        hi_q       <= alu_hi;
                        lo_q       <= alu_lo;
                        rsp_data_q <= alu_lo;
                        rsp_zero_q <= alu_zero;
                        rsp_ovf_q  <= 1'b0;
                        rsp_ill_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_RESP);
    assign alu_sel      = op_q[3:0];
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_carry_in = 1'b0;
    assign alu_sign     = sign_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_ovf_trap = rsp_ovf_q;
    assign rsp_illegal  = rsp_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Purpose  : Directed vector bench for alu_exec_ctrl with a small ALU stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        req_sign;
    logic [3:0]  alu_sel;
    logic [31:0] alu_a, alu_b;
    logic        alu_carry_in, alu_sign;
    logic [31:0] alu_hi, alu_lo;
    logic        alu_zero, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_ovf_trap, rsp_illegal;
    logic [31:0] hi_q, lo_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.MUL_LAT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_sign(req_sign),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_carry_in(alu_carry_in), .alu_sign(alu_sign),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_ovf_trap(rsp_ovf_trap),
        .rsp_illegal(rsp_illegal), .hi_q(hi_q), .lo_q(lo_q)
    );

    // Stand-in ALU: 0 ADD, 1 SUB, 2 MULT, 3 AND, others XOR. The adder
    // overflow flag is reported for every non-SUB op, as a real adder would.
    logic [31:0] w_sum, w_diff;
    logic [63:0] w_res;
    always_comb begin
        w_sum  = alu_a + alu_b;
        w_diff = alu_a - alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (w_sum[31] != alu_a[31]);
        case (alu_sel)
            4'd0: w_res = {32'h0, w_sum};
            4'd1: begin
                w_res = {32'h0, w_diff};
                alu_overflow = (alu_a[31] != alu_b[31]) && (w_diff[31] != alu_a[31]);
            end
            4'd2: w_res = alu_sign ?
                    ($signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b})) :
                    ({32'h0, alu_a} * {32'h0, alu_b});
            4'd3: w_res = {32'h0, alu_a & alu_b};
            default: w_res = {32'h0, alu_a ^ alu_b};
        endcase
        alu_hi   = w_res[63:32];
        alu_lo   = w_res[31:0];
        alu_zero = (w_res == 64'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic s, output logic [31:0] d, output logic z,
                         output logic o, output logic il, output int lat);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_sign = s; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 32'hA5A5_A5A5;
        wait_rsp(lat);
        d = rsp_data; z = rsp_zero; o = rsp_ovf_trap; il = rsp_illegal;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        sign;
        logic [31:0] data;
        logic        zero, ovf, ill;
        logic [31:0] hi, lo;
        int          lat;
    } vec_t;

    function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic s,
                                logic [31:0] d, logic z, logic o, logic il,
                                logic [31:0] h, logic [31:0] l, int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sign = s; v.data = d; v.zero = z;
        v.ovf = o; v.ill = il; v.hi = h; v.lo = l; v.lat = lat;
        return v;
    endfunction

    vec_t vt[16];

    initial begin
        logic [31:0] d;
        logic        z, o, il;
        int          lat, seen;

        vt[0]  = mk(5'h00, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 0, 1, 0, 32'h0, 32'h0, 2);
        vt[1]  = mk(5'h00, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 0, 0, 0, 32'h0, 32'h0, 2);
        vt[2]  = mk(5'h01, 32'h5, 32'h5, 1'b0, 32'h0, 1, 0, 0, 32'h0, 32'h0, 2);
        vt[3]  = mk(5'h02, 32'h00010000, 32'h00010000, 1'b0, 32'h0, 0, 0, 0, 32'h1, 32'h0, 6);
        vt[4]  = mk(5'h10, 32'h0, 32'h0, 1'b0, 32'h1, 0, 0, 0, 32'h1, 32'h0, 2);
        vt[5]  = mk(5'h13, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, 0, 32'h1, 32'hDEADBEEF, 2);
        vt[6]  = mk(5'h11, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, 0, 32'h1, 32'hDEADBEEF, 2);
        vt[7]  = mk(5'h10, 32'h0, 32'h0, 1'b0, 32'h1, 0, 0, 0, 32'h1, 32'hDEADBEEF, 2);
        vt[8]  = mk(5'h1F, 32'h123, 32'h5, 1'b0, 32'h0, 1, 0, 1, 32'h1, 32'hDEADBEEF, 2);
        vt[9]  = mk(5'h11, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, 0, 32'h1, 32'hDEADBEEF, 2);
        vt[10] = mk(5'h01, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 0, 1, 0, 32'h1, 32'hDEADBEEF, 2);
        vt[11] = mk(5'h12, 32'h0, 32'h9, 1'b0, 32'h0, 1, 0, 0, 32'h0, 32'hDEADBEEF, 2);
        vt[12] = mk(5'h03, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h1, 0, 0, 0, 32'h0, 32'hDEADBEEF, 2);
        vt[13] = mk(5'h02, 32'hFFFFFFFF, 32'h2, 1'b1, 32'hFFFFFFFE, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 6);
        vt[14] = mk(5'h14, 32'h77, 32'h1, 1'b1, 32'h0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
        vt[15] = mk(5'h10, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);

        reset_n = 1'b0; req_valid = 1'b0; req_op = 5'h0; req_a = 32'h0; req_b = 32'h0;
        req_sign = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset alu_sel", 32'(alu_sel), 32'h0);
        chk("reset alu_a", alu_a, 32'h0);
        chk("reset alu_b", alu_b, 32'h0);
        chk("reset alu_sign", 32'(alu_sign), 32'h0);
        chk("reset hi_q", hi_q, 32'h0);
        chk("reset lo_q", lo_q, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sign, d, z, o, il, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d rsp_data", i), d, vt[i].data);
            chk($sformatf("v%0d rsp_zero", i), 32'(z), 32'(vt[i].zero));
            chk($sformatf("v%0d rsp_ovf_trap", i), 32'(o), 32'(vt[i].ovf));
            chk($sformatf("v%0d rsp_illegal", i), 32'(il), 32'(vt[i].ill));
            chk($sformatf("v%0d hi_q", i), hi_q, vt[i].hi);
            chk($sformatf("v%0d lo_q", i), lo_q, vt[i].lo);
        end

        // Backpressure: a second request waits until the handshake completes.
        @(negedge clk);
        req_op = 5'h00; req_a = 32'h3; req_b = 32'h4; req_sign = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_op = 5'h11; req_a = 32'h0; req_b = 32'h0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d rsp_data", i), rsp_data, 32'h7);
            chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'h0);
            @(posedge clk);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp req_ready after handshake", 32'(req_ready), 32'h1);
        chk("bp rsp_valid after handshake", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(lat);
        chk("bp second latency", 32'(lat), 32'h2);
        chk("bp second rsp_data", rsp_data, 32'hFFFFFFFE);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the second MULW cycle drops the multiply.
        chk("pre-reset hi_q", hi_q, 32'hFFFFFFFF);
        req_op = 5'h02; req_a = 32'h00010000; req_b = 32'h00010000; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset req_ready", 32'(req_ready), 32'h1);
        chk("mid reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid reset hi_q", hi_q, 32'h0);
        chk("mid reset lo_q", lo_q, 32'h0);
        chk("mid reset alu_a", alu_a, 32'h0);
        reset_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("dropped op response count", 32'(seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
